// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus for the shared sequential divider.
// The requester drives the operands and start; the divider returns results and status.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );

endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: fixed WIDTH+1 cycle latency,
// one quotient bit per RUN cycle, divide-by-zero short-circuits straight to DONE.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PR_W  = WIDTH + 1;
    localparam int unsigned TR_W  = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PR_W-1:0]  partial_rem;
    logic [WIDTH-1:0] dividend_sh;
    logic [WIDTH-1:0] divisor_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             done_q;
    logic             dbz_q;

    logic             accept;
    logic             last_iter;
    logic             divisor_zero;

    logic [TR_W-1:0]  shifted;
    logic [TR_W-1:0]  trial;
    logic             trial_neg;
    logic [PR_W-1:0]  rem_next;
    logic [WIDTH-1:0] quo_next;

    assign divisor_zero = (bus.divisor == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = divisor_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_iter  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One restoring iteration; the extra top bit keeps the trial sign visible
    always_comb begin
        shifted   = {partial_rem, dividend_sh[WIDTH-1]};
        trial     = shifted - TR_W'(divisor_q);
        trial_neg = trial[TR_W-1];
        rem_next  = trial_neg ? shifted[PR_W-1:0] : trial[PR_W-1:0];
        quo_next  = {dividend_sh[WIDTH-2:0], ~trial_neg};
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            partial_rem <= '0;
            dividend_sh <= '0;
            divisor_q   <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= (state_next == S_DONE);
            if (accept) begin
                partial_rem <= '0;
                dividend_sh <= bus.dividend;
                divisor_q   <= bus.divisor;
                cnt         <= '0;
                dbz_q       <= divisor_zero;
                if (divisor_zero) begin
                    quotient_q  <= '1;
                    remainder_q <= bus.dividend;
                end
            end else if (state == S_RUN) begin
                partial_rem <= rem_next;
                dividend_sh <= quo_next;
                cnt         <= cnt + CNT_W'(1);
                if (last_iter) begin
                    quotient_q  <= quo_next;
                    remainder_q <= rem_next[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: table of operations on 16- and 8-bit instances
// plus hand sequences for busy-start, mid-operation reset and reset/start collisions.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(16)) bus16 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    seq_divider #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          w8;
        logic [15:0] dd;
        logic [15:0] dv;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit w8, input logic [15:0] dd, input logic [15:0] dv);
        if (w8) begin
            bus8.dividend = dd[7:0];
            bus8.divisor  = dv[7:0];
            bus8.start    = 1'b1;
        end else begin
            bus16.dividend = dd;
            bus16.divisor  = dv;
            bus16.start    = 1'b1;
        end
    endtask

    task automatic drop_start();
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
    endtask

    // Waits (bounded) for done; lat = -1 if it never arrives
    task automatic wait_done(input bit w8, input int limit, output int lat,
                             output logic [15:0] q, output logic [15:0] r,
                             output logic z, output bit busy_ok);
        lat     = -1;
        q       = '0;
        r       = '0;
        z       = 1'b0;
        busy_ok = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            step();
            if (c == 1) drop_start();
            if (w8 ? bus8.done : bus16.done) begin
                lat = c;
                q   = w8 ? {8'h00, bus8.quotient}  : bus16.quotient;
                r   = w8 ? {8'h00, bus8.remainder} : bus16.remainder;
                z   = w8 ? bus8.div_by_zero : bus16.div_by_zero;
                if (!(w8 ? bus8.busy : bus16.busy)) busy_ok = 1'b0;
                break;
            end
            if (!(w8 ? bus8.busy : bus16.busy)) busy_ok = 1'b0;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (bus16.done) n++;
        end
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        bit          busy_ok;

        vecs[0]  = '{1'b0, 16'd1234,  16'd10,    16'd123,   16'd4,   1'b0, 17};
        vecs[1]  = '{1'b0, 16'd9,     16'd10,    16'd0,     16'd9,   1'b0, 17};
        vecs[2]  = '{1'b0, 16'd65535, 16'd1,     16'd65535, 16'd0,   1'b0, 17};
        vecs[3]  = '{1'b0, 16'd500,   16'd0,     16'hFFFF,  16'd500, 1'b1, 1};
        vecs[4]  = '{1'b0, 16'd20,    16'd3,     16'd6,     16'd2,   1'b0, 17};
        vecs[5]  = '{1'b0, 16'd65535, 16'd65535, 16'd1,     16'd0,   1'b0, 17};
        vecs[6]  = '{1'b0, 16'd0,     16'd5,     16'd0,     16'd0,   1'b0, 17};
        vecs[7]  = '{1'b0, 16'd100,   16'd200,   16'd0,     16'd100, 1'b0, 17};
        vecs[8]  = '{1'b0, 16'd65534, 16'd255,   16'd256,   16'd254, 1'b0, 17};
        vecs[9]  = '{1'b0, 16'd1,     16'd0,     16'hFFFF,  16'd1,   1'b1, 1};
        vecs[10] = '{1'b1, 16'd200,   16'd7,     16'd28,    16'd4,   1'b0, 9};
        vecs[11] = '{1'b1, 16'd255,   16'd255,   16'd1,     16'd0,   1'b0, 9};
        vecs[12] = '{1'b1, 16'd0,     16'd0,     16'h00FF,  16'd0,   1'b1, 1};
        vecs[13] = '{1'b1, 16'd13,    16'd200,   16'd0,     16'd13,  1'b0, 9};
        vecs[14] = '{1'b1, 16'd255,   16'd1,     16'd255,   16'd0,   1'b0, 9};

        rst = 1'b1;
        drop_start();
        bus16.dividend = '0;
        bus16.divisor  = '0;
        bus8.dividend  = '0;
        bus8.divisor   = '0;
        repeat (3) step();

        chk("rst_q16",    32'(bus16.quotient),    0);
        chk("rst_r16",    32'(bus16.remainder),   0);
        chk("rst_busy16", 32'(bus16.busy),        0);
        chk("rst_done16", 32'(bus16.done),        0);
        chk("rst_dbz16",  32'(bus16.div_by_zero), 0);
        chk("rst_busy8",  32'(bus8.busy),         0);
        chk("rst_q8",     32'(bus8.quotient),     0);
        rst = 1'b0;
        step();

        // Each vector starts in the cycle right after the previous done
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].w8, vecs[i].dd, vecs[i].dv);
            wait_done(vecs[i].w8, 40, lat, q, r, z, busy_ok);
            chk($sformatf("vec%0d_lat", i),  32'(lat),     32'(vecs[i].lat));
            chk($sformatf("vec%0d_q", i),    32'(q),       32'(vecs[i].q));
            chk($sformatf("vec%0d_r", i),    32'(r),       32'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i),  32'(z),       32'(vecs[i].z));
            chk($sformatf("vec%0d_busy", i), 32'(busy_ok), 1);
            step();
            chk($sformatf("vec%0d_idle_busy", i),
                32'(vecs[i].w8 ? bus8.busy : bus16.busy), 0);
            chk($sformatf("vec%0d_one_done", i),
                32'(vecs[i].w8 ? bus8.done : bus16.done), 0);
            chk($sformatf("vec%0d_hold_q", i),
                32'(vecs[i].w8 ? {8'h00, bus8.quotient} : bus16.quotient), 32'(vecs[i].q));
            chk($sformatf("vec%0d_hold_dbz", i),
                32'(vecs[i].w8 ? bus8.div_by_zero : bus16.div_by_zero), 32'(vecs[i].z));
        end

        // start re-pulsed while RUN, operands toggled afterwards: ignored
        issue(1'b0, 16'd1000, 16'd7);
        ndone = 0;
        lat   = -1;
        q     = '0;
        r     = '0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus16.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    q   = bus16.quotient;
                    r   = bus16.remainder;
                end
            end
            if (c == 1) drop_start();
            if (c == 5) issue(1'b0, 16'd50, 16'd5);
            if (c == 6) begin
                drop_start();
                bus16.dividend = 16'd777;
                bus16.divisor  = 16'd3;
            end
        end
        chk("busy_start_ndone", 32'(ndone), 1);
        chk("busy_start_lat",   32'(lat),   17);
        chk("busy_start_q",     32'(q),     142);
        chk("busy_start_r",     32'(r),     6);

        // Synchronous reset in the middle of an operation
        issue(1'b0, 16'd40000, 16'd3);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) drop_start();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(bus16.busy),      0);
        chk("abort_done", 32'(bus16.done),      0);
        chk("abort_q",    32'(bus16.quotient),  0);
        chk("abort_r",    32'(bus16.remainder), 0);
        count_done(25, ndone);
        chk("abort_no_done", 32'(ndone), 0);

        issue(1'b0, 16'd40000, 16'd3);
        wait_done(1'b0, 40, lat, q, r, z, busy_ok);
        chk("fresh_lat", 32'(lat), 17);
        chk("fresh_q",   32'(q),   13333);
        chk("fresh_r",   32'(r),   1);
        step();

        // rst and start in the same cycle: start dropped
        rst = 1'b1;
        issue(1'b0, 16'd100, 16'd3);
        step();
        rst = 1'b0;
        drop_start();
        chk("rst_start_busy", 32'(bus16.busy), 0);
        count_done(25, ndone);
        chk("rst_start_no_done", 32'(ndone), 0);

        // start during the DONE cycle is ignored
        issue(1'b0, 16'd50, 16'd5);
        wait_done(1'b0, 40, lat, q, r, z, busy_ok);
        chk("done_start_q", 32'(q), 10);
        issue(1'b0, 16'd7, 16'd7);
        step();
        drop_start();
        chk("done_start_busy", 32'(bus16.busy), 0);
        count_done(25, ndone);
        chk("done_start_no_done", 32'(ndone), 0);
        chk("done_start_hold_q", 32'(bus16.quotient), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised unsigned sequential divider with a start/done handshake; next generation of the fixed divide-by-10 repeated-subtraction unit.
- Accepts arbitrary dividend and divisor of WIDTH bits and returns quotient and remainder.
- Uses restoring shift-subtract, so latency is fixed at WIDTH+1 cycles independent of operand values.
- Flags divide-by-zero; sits beside the datapath/controller pairs as a shared arithmetic resource.

Parameters:
WIDTH, 16, operand, quotient and remainder width in bits (legal range 2..32).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
dividend  input  WIDTH  unsigned dividend, captured on accepted start.
divisor  input  WIDTH  unsigned divisor, captured on accepted start.
quotient  output  WIDTH  result quotient (registered).
remainder  output  WIDTH  result remainder (registered).
busy  output  1  high while an operation is in progress (state != IDLE).
done  output  1  one-cycle pulse when results are valid.
div_by_zero  output  1  set with done when the captured divisor was 0.

Behaviour:
- Reset: the synchronous rst overrides everything.
  - state=IDLE.
  - quotient, remainder, busy, done and div_by_zero are all 0.
  - Internal partial remainder, shift register and iteration counter are cleared.
- FSM states:
  - IDLE: wait for start. start=1 loads the operands and clears the partial remainder and the iteration counter.
    - Divisor == 0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: one iteration per cycle.
    - Shift {partial_rem, dividend_sh} left by 1.
    - Trial-subtract divisor from the (WIDTH+1)-bit partial remainder.
    - If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
    - Counter increments each iteration. After iteration WIDTH (counter == WIDTH-1 at the edge), go to DONE.
  - DONE: for one cycle.
    - done=1.
    - quotient and remainder registers are updated on entry and then hold.
    - Next state is unconditionally IDLE.
- Latency:
  - start high in cycle 0 gives RUN in cycles 1..WIDTH and done=1 in cycle WIDTH+1.
  - Divide-by-zero: done=1 in cycle 1.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1. div_by_zero holds until the next accepted start or rst.
- Output hold: quotient, remainder and div_by_zero hold their last values after done until the next accepted start. They are not cleared on return to IDLE.
- busy:
  - 1 in RUN and DONE; 0 in IDLE.
  - Combinational from state; registered state only.
- start while busy (RUN or DONE) is ignored; operands are not recaptured and there is no queueing.
- Back-to-back: start asserted in the cycle after done (IDLE) is accepted. The minimum spacing between accepted starts is WIDTH+2 cycles.
- Operand changes after capture have no effect on the operation in flight.
- Internal arithmetic:
  - Partial remainder is WIDTH+1 bits so the trial subtraction never overflows.
  - Final remainder < divisor is guaranteed for divisor != 0.
- rst mid-operation: abort immediately; next cycle is IDLE with all outputs 0 and no done pulse.
- rst and start in the same cycle: rst wins and start is dropped.

Test Plan:
- WIDTH=16, dividend=1234, divisor=10, start in cycle 0 -> done=1 only in cycle 17; quotient=123, remainder=4, div_by_zero=0; busy high cycles 1..17.
- WIDTH=16, 9/10 then 65535/1 issued back-to-back at the earliest accepted cycle:
  - first result quotient=0, remainder=9;
  - second result quotient=65535, remainder=0;
  - second start accepted in the cycle after the first done.
- WIDTH=16, 500/0 -> done in cycle 1, quotient=16'hFFFF, remainder=500, div_by_zero=1. A following 20/3 -> quotient=6, remainder=2, div_by_zero=0.
- WIDTH=16, 1000/7 started; start re-pulsed with 50/5 in cycle 5; operands toggled in cycle 6 -> single done in cycle 17 with quotient=142, remainder=6.
- WIDTH=16, 40000/3 started; rst high in cycle 8 -> cycle 9: busy=0, done=0, quotient=0, remainder=0, and no done appears afterwards. A fresh 40000/3 -> quotient=13333, remainder=1.
- WIDTH=8 instance: 200/7 -> done in cycle 9, quotient=28, remainder=4. 255/255 -> quotient=1, remainder=0.
